rename_stage: RTL and testbench
===============================

# rename_stage

Two-wide register-rename stage that sits directly upstream of the dispatch stage. It maps architectural source and destination registers to physical registers using a speculative RAT (register alias table) and a circular free list. Results are registered into the rename/dispatch pipeline register that drives `rename_valid` and the renamed instructions. Commit-time updates of a committed RAT and free-list head allow a single-cycle recovery on `flush`.

## Interface
- `ARCH_REGS`, 32, architectural register count (x0 hard-mapped to p0)
- `PHY_REGS`, 64, physical register count
- `PHY_WIDTH`, 6, log2(PHY_REGS)
- `FL_DEPTH`, PHY_REGS-ARCH_REGS (32), free-list entries

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush`  in  1  mispredict/exception recovery
- `stall_rename`  in  1  dispatch/ROB back-pressure
- `decode_valid`  in  2  per-slot valid; slot 0 is older
- `decode_rs1_{0,1}`, `decode_rs2_{0,1}`, `decode_rd_{0,1}`  in  5 each  architectural registers
- `decode_rd_we_{0,1}`  in  1 each  slot writes rd
- `decode_ready`  out  1  pair accepted this cycle when `decode_valid!=0`
- `rename_valid`  out  2  registered slot valid to dispatch
- `prs1_{0,1}`, `prs2_{0,1}`, `prd_{0,1}`, `old_prd_{0,1}`  out  PHY_WIDTH each  registered mappings; `old_prd` goes to the ROB
- `commit_valid`  in  2  retiring slots that write rd; slot 0 is older
- `commit_rd_{0,1}`  in  5  architectural rd
- `commit_prd_{0,1}`, `commit_old_prd_{0,1}`  in  PHY_WIDTH  new mapping, register to free
- `freelist_err`  out  1  sticky error flag; see Configuration

## Operation
- Allocation need: a slot needs a register when it is valid, `rd_we`=1 and rd≠0. `need` ranges 0–2.
- `decode_ready` = !`stall_rename` && !`flush` && (`spec_count` ≥ `need`). Combinational.
- A pair is accepted all-or-nothing. It is never split.
- Source lookup reads the speculative RAT.
- Slot 1 bypass: if slot 1's rs1/rs2 equals slot 0's rd, and slot 0 allocates, slot 1 uses slot 0's new prd.
- Slot 1 `old_prd`: if slot 1's rd equals slot 0's rd and slot 0 allocates, `old_prd_1` = `prd_0`.
- On accept, allocations pop at the speculative head, slot 0 first. Speculative RAT[rd] is written; slot 1 wins on a same-rd collision.
- Non-allocating slot: `prd`=0 and `old_prd`=0. x0 always reads as p0.
- Free list: circular buffer of FL_DEPTH entries. Pointers carry a wrap bit.
  - `spec_head` advances on allocation.
  - `commit_head` advances once per commit slot.
  - `tail` receives `commit_old_prd` for each commit slot, slot 0 first.
- Committed RAT[commit_rd]=commit_prd; slot 1 wins on collision. Commits with rd=0 are not presented.
- Invariant: `tail` − `commit_head` = FL_DEPTH at all times.
- Flush recovery:
  - Speculative RAT ← committed RAT, including same-cycle commits.
  - `spec_head` ← `commit_head`, including same-cycle advance.
  - `rename_valid` ← 0.
  - The accept is suppressed.
- Reset:
  - Both RATs map i→i.
  - Free list holds p32..p63 in order.
  - `spec_head`=`commit_head`=0, `tail`=FL_DEPTH with wrap bit set.
  - All outputs 0.

## Timing
- Latency: an accepted pair appears on `rename_*` on the next rising edge.
- On an accept edge, the output register loads the accepted pair and `rename_valid` = accepted `decode_valid`.
- Edge with `stall_rename` and no flush: the output register holds.
- Edge with no accept and no stall: `rename_valid` ← 0.
- A commit push to the tail becomes allocatable on the cycle after the commit. There is no same-cycle bypass.
- Speculative RAT writes become visible to the lookup of the next accepted pair.
- Simultaneous flush and commit: commits are applied first, then restore.
- Empty free list (`spec_count`=0): a pair with `need`≥1 stalls. A pair with `need`=0 is accepted.
- Pointer wrap: indices wrap modulo FL_DEPTH, and the wrap bit toggles.
- Reset asserted mid-operation returns all state to reset values asynchronously.

## Configuration
- `RENAME_FREELIST_CHECK_EN`:
  - Defined: `freelist_err` sets and stays set until reset on any of:
    - allocation with `spec_count` < `need`
    - a commit push while `tail` − `commit_head` ≠ FL_DEPTH
    - a freed `old_prd` equal to 0
    
    Simulation assertions fire on the same conditions.
  - Undefined: `freelist_err` is tied to 0 and no checking logic is built.

## Test plan
- Reset, then accept add x5 / add x6 (rd_we) → `prd_0`=32, `prd_1`=33, `old_prd_0`=5, `old_prd_1`=6, `rename_valid`=2'b11 one cycle later.
- Pair with slot 0 rd=x7 and slot 1 rs1=x7, rd=x7 → `prs1_1`=`prd_0`=32, `prd_1`=33, `old_prd_1`=32.
- Allocate 32 registers with no commits → `decode_ready`=0 for an rd-writing pair and 1 for a store/branch pair. Commit one slot → allocation is possible the following cycle.
- Rename 3 pairs, commit the first pair, then flush → next lookup of those rds returns committed mappings and `spec_head` equals `commit_head`. Flush and commit in the same cycle → the commit is reflected.
- `stall_rename` held 3 cycles with a valid output → outputs hold, `decode_ready`=0, no pointer movement. Run more than 64 allocations with commits → pointers wrap with correct mappings.
- With the macro defined, force a commit with `old_prd`=0 → `freelist_err`=1 and it remains set until `rst` is asserted low.

Source files
------------

// File: rtl/rename_stage_if.sv
// Decode, rename-output and commit signal bundle for rename_stage.
interface rename_stage_if #(
  parameter int PHY_WIDTH = 6,
  parameter int AW        = 5
);
  logic                 flush;
  logic                 stall_rename;
  logic [1:0]           decode_valid;
  logic [AW-1:0]        decode_rs1_0, decode_rs1_1;
  logic [AW-1:0]        decode_rs2_0, decode_rs2_1;
  logic [AW-1:0]        decode_rd_0,  decode_rd_1;
  logic                 decode_rd_we_0, decode_rd_we_1;
  logic                 decode_ready;
  logic [1:0]           rename_valid;
  logic [PHY_WIDTH-1:0] prs1_0, prs1_1, prs2_0, prs2_1;
  logic [PHY_WIDTH-1:0] prd_0, prd_1, old_prd_0, old_prd_1;
  logic [1:0]           commit_valid;
  logic [AW-1:0]        commit_rd_0, commit_rd_1;
  logic [PHY_WIDTH-1:0] commit_prd_0, commit_prd_1;
  logic [PHY_WIDTH-1:0] commit_old_prd_0, commit_old_prd_1;
  logic                 freelist_err;

  modport slave (
    input  flush, stall_rename, decode_valid,
           decode_rs1_0, decode_rs1_1, decode_rs2_0, decode_rs2_1,
           decode_rd_0, decode_rd_1, decode_rd_we_0, decode_rd_we_1,
           commit_valid, commit_rd_0, commit_rd_1,
           commit_prd_0, commit_prd_1, commit_old_prd_0, commit_old_prd_1,
    output decode_ready, rename_valid,
           prs1_0, prs1_1, prs2_0, prs2_1, prd_0, prd_1, old_prd_0, old_prd_1,
           freelist_err
  );

  modport master (
    output flush, stall_rename, decode_valid,
           decode_rs1_0, decode_rs1_1, decode_rs2_0, decode_rs2_1,
           decode_rd_0, decode_rd_1, decode_rd_we_0, decode_rd_we_1,
           commit_valid, commit_rd_0, commit_rd_1,
           commit_prd_0, commit_prd_1, commit_old_prd_0, commit_old_prd_1,
    input  decode_ready, rename_valid,
           prs1_0, prs1_1, prs2_0, prs2_1, prd_0, prd_1, old_prd_0, old_prd_1,
           freelist_err
  );
endinterface

// File: rtl/rename_stage.sv
// Two-wide rename stage: speculative/committed RATs plus circular free list with one-cycle flush recovery.
// Optional free-list consistency checking is built when RENAME_FREELIST_CHECK_EN is defined.
module rename_lane #(
  parameter int ARCH_REGS = 32,
  parameter int PHY_WIDTH = 6,
  parameter int AW        = 5
) (
  input  logic [ARCH_REGS-1:0][PHY_WIDTH-1:0] spec_rat_i,
  input  logic [AW-1:0]                       rs1_i,
  input  logic [AW-1:0]                       rs2_i,
  input  logic [AW-1:0]                       rd_i,
  input  logic                                need_i,
  input  logic [PHY_WIDTH-1:0]                new_prd_i,
  input  logic                                byp_en_i,
  input  logic [AW-1:0]                       byp_rd_i,
  input  logic [PHY_WIDTH-1:0]                byp_prd_i,
  output logic [PHY_WIDTH-1:0]                prs1_o,
  output logic [PHY_WIDTH-1:0]                prs2_o,
  output logic [PHY_WIDTH-1:0]                prd_o,
  output logic [PHY_WIDTH-1:0]                old_prd_o
);
  logic [PHY_WIDTH-1:0] rat_rs1, rat_rs2, rat_rd;

  assign rat_rs1 = (rs1_i == '0) ? '0 : spec_rat_i[rs1_i];
  assign rat_rs2 = (rs2_i == '0) ? '0 : spec_rat_i[rs2_i];
  assign rat_rd  = spec_rat_i[rd_i];

  // an allocating older slot in the same pair overrides the RAT read
  assign prs1_o    = (byp_en_i && rs1_i == byp_rd_i) ? byp_prd_i : rat_rs1;
  assign prs2_o    = (byp_en_i && rs2_i == byp_rd_i) ? byp_prd_i : rat_rs2;
  assign prd_o     = need_i ? new_prd_i : '0;
  assign old_prd_o = !need_i ? '0 :
                     (byp_en_i && rd_i == byp_rd_i) ? byp_prd_i : rat_rd;
endmodule

module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHY_REGS  = 64,
  parameter int PHY_WIDTH = 6
) (
  input logic           clk,
  input logic           rst,
  rename_stage_if.slave rn_if
);
  localparam int FL_DEPTH  = PHY_REGS - ARCH_REGS;
  localparam int FLW       = $clog2(FL_DEPTH);
  localparam int PTRW      = FLW + 1;
  localparam int AW        = $clog2(ARCH_REGS);
  localparam int NUM_LANES = 2;

  typedef logic [PHY_WIDTH-1:0] preg_t;
  typedef logic [PTRW-1:0]      ptr_t;
  typedef struct packed {
    logic          vld;
    logic          we;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
  } dec_req_t;
  typedef struct packed {
    logic          vld;
    logic [AW-1:0] rd;
    preg_t         prd;
    preg_t         old_prd;
  } cmt_req_t;
  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
  } ren_rsp_t;

  preg_t [ARCH_REGS-1:0] spec_rat_q, spec_rat_d, cmt_rat_q, cmt_rat_d;
  preg_t [FL_DEPTH-1:0]  fl_q, fl_d;
  ptr_t                  spec_head_q, spec_head_d, cmt_head_q, cmt_head_d;
  ptr_t                  tail_q, tail_d, push_ptr, spec_count, alloc_ptr1;

  dec_req_t [NUM_LANES-1:0] dec;
  cmt_req_t [NUM_LANES-1:0] cmt;
  ren_rsp_t [NUM_LANES-1:0] ren_d, ren_q;
  logic     [NUM_LANES-1:0] need, rvld_q;
  preg_t    [NUM_LANES-1:0] new_prd;
  logic     [1:0]           n_alloc;
  logic                     ready, accept;

  assign dec[0] = '{vld: rn_if.decode_valid[0], we: rn_if.decode_rd_we_0,
                    rs1: rn_if.decode_rs1_0, rs2: rn_if.decode_rs2_0, rd: rn_if.decode_rd_0};
  assign dec[1] = '{vld: rn_if.decode_valid[1], we: rn_if.decode_rd_we_1,
                    rs1: rn_if.decode_rs1_1, rs2: rn_if.decode_rs2_1, rd: rn_if.decode_rd_1};
  assign cmt[0] = '{vld: rn_if.commit_valid[0], rd: rn_if.commit_rd_0,
                    prd: rn_if.commit_prd_0, old_prd: rn_if.commit_old_prd_0};
  assign cmt[1] = '{vld: rn_if.commit_valid[1], rd: rn_if.commit_rd_1,
                    prd: rn_if.commit_prd_1, old_prd: rn_if.commit_old_prd_1};

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++)
      need[l] = dec[l].vld && dec[l].we && (dec[l].rd != '0);
  end

  assign n_alloc    = {1'b0, need[0]} + {1'b0, need[1]};
  // wrap bits make tail - head the true occupancy, 0..FL_DEPTH
  assign spec_count = tail_q - spec_head_q;
  assign ready      = !rn_if.stall_rename && !rn_if.flush && (spec_count >= ptr_t'(n_alloc));
  assign accept     = ready && (|rn_if.decode_valid);
  assign rn_if.decode_ready = ready;

  assign alloc_ptr1 = spec_head_q + ptr_t'(need[0]);
  assign new_prd[0] = fl_q[spec_head_q[FLW-1:0]];
  assign new_prd[1] = fl_q[alloc_ptr1[FLW-1:0]];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic          byp_en;
    logic [AW-1:0] byp_rd;
    preg_t         byp_prd;
    preg_t         prs1, prs2, prd, old_prd;
    if (l == 0) begin : g_oldest
      assign byp_en  = 1'b0;
      assign byp_rd  = '0;
      assign byp_prd = '0;
    end else begin : g_younger
      assign byp_en  = need[l-1];
      assign byp_rd  = dec[l-1].rd;
      assign byp_prd = new_prd[l-1];
    end
    rename_lane #(.ARCH_REGS(ARCH_REGS), .PHY_WIDTH(PHY_WIDTH), .AW(AW)) u_lane (
      .spec_rat_i (spec_rat_q),
      .rs1_i      (dec[l].rs1),
      .rs2_i      (dec[l].rs2),
      .rd_i       (dec[l].rd),
      .need_i     (need[l]),
      .new_prd_i  (new_prd[l]),
      .byp_en_i   (byp_en),
      .byp_rd_i   (byp_rd),
      .byp_prd_i  (byp_prd),
      .prs1_o     (prs1),
      .prs2_o     (prs2),
      .prd_o      (prd),
      .old_prd_o  (old_prd)
    );
    assign ren_d[l] = '{prs1: prs1, prs2: prs2, prd: prd, old_prd: old_prd};
  end

  // commit side: slot 0 is older, so slot 1 lands later in both the RAT and the tail
  always_comb begin
    cmt_rat_d = cmt_rat_q;
    fl_d      = fl_q;
    push_ptr  = tail_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (cmt[l].vld) begin
        cmt_rat_d[cmt[l].rd]    = cmt[l].prd;
        fl_d[push_ptr[FLW-1:0]] = cmt[l].old_prd;
        push_ptr                = push_ptr + ptr_t'(1);
      end
    end
  end

  assign tail_d     = push_ptr;
  assign cmt_head_d = cmt_head_q + (push_ptr - tail_q);

  always_comb begin
    spec_rat_d = spec_rat_q;
    if (rn_if.flush) begin
      spec_rat_d = cmt_rat_d;
    end else if (accept) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (need[l]) spec_rat_d[dec[l].rd] = new_prd[l];
    end
  end

  assign spec_head_d = rn_if.flush ? cmt_head_d :
                       accept      ? spec_head_q + ptr_t'(n_alloc) : spec_head_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat_q[i] <= preg_t'(i);
        cmt_rat_q[i]  <= preg_t'(i);
      end
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= preg_t'(ARCH_REGS + i);
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= ptr_t'(FL_DEPTH);
    end else begin
      spec_rat_q  <= spec_rat_d;
      cmt_rat_q   <= cmt_rat_d;
      fl_q        <= fl_d;
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvld_q <= '0;
      ren_q  <= '0;
    end else if (rn_if.flush) begin
      rvld_q <= '0;
    end else if (accept) begin
      rvld_q <= rn_if.decode_valid;
      ren_q  <= ren_d;
    end else if (!rn_if.stall_rename) begin
      rvld_q <= '0;
    end
  end

  assign rn_if.rename_valid = rvld_q;
  assign rn_if.prs1_0    = ren_q[0].prs1;
  assign rn_if.prs2_0    = ren_q[0].prs2;
  assign rn_if.prd_0     = ren_q[0].prd;
  assign rn_if.old_prd_0 = ren_q[0].old_prd;
  assign rn_if.prs1_1    = ren_q[1].prs1;
  assign rn_if.prs2_1    = ren_q[1].prs2;
  assign rn_if.prd_1     = ren_q[1].prd;
  assign rn_if.old_prd_1 = ren_q[1].old_prd;

`ifdef RENAME_FREELIST_CHECK_EN
  logic err_q, err_over, err_occ, err_zero;

  assign err_over = accept && (spec_count < ptr_t'(n_alloc));
  assign err_occ  = (|rn_if.commit_valid) && ((tail_q - cmt_head_q) != ptr_t'(FL_DEPTH));
  assign err_zero = (cmt[0].vld && cmt[0].old_prd == '0) || (cmt[1].vld && cmt[1].old_prd == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | err_over | err_occ | err_zero;
  end

  always @(posedge clk) begin
    if (rst) begin
      a_over: assert (!err_over) else $warning("rename: allocation beyond free-list occupancy");
      a_occ:  assert (!err_occ)  else $warning("rename: free-list occupancy broken at commit");
      a_zero: assert (!err_zero) else $warning("rename: p0 returned to free list");
    end
  end

  assign rn_if.freelist_err = err_q;
`else
  assign rn_if.freelist_err = 1'b0;
`endif
endmodule

// File: tb/tb_rename_stage.sv
// Randomized bench for rename_stage against a sequential map/queue model, plus literal spot checks.
module tb_rename_stage;
  localparam int FL_DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rename_stage_if #(.PHY_WIDTH(6), .AW(5)) bus ();
  rename_stage dut (.clk(clk), .rst(rst), .rn_if(bus));

  int n_chk = 0;
  int n_fail = 0;

  // model: architectural maps, committed-order free list, in-flight allocations
  int spec_map[32];
  int cmt_map[32];
  int fl[$];
  int spec_off;
  int rob_rd[$], rob_prd[$], rob_old[$];
  logic [1:0] e_vld;
  int e_prs1[2], e_prs2[2], e_prd[2], e_old[2];

  // stimulus for the next cycle
  logic       d_flush, d_stall;
  logic [1:0] d_dv;
  logic [4:0] d_rs1[2], d_rs2[2], d_rd[2];
  logic       d_we[2];
  int         d_ncmt;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin spec_map[i] = i; cmt_map[i] = i; end
    fl.delete();
    for (int i = 0; i < FL_DEPTH; i++) fl.push_back(32 + i);
    spec_off = 0;
    rob_rd.delete(); rob_prd.delete(); rob_old.delete();
    e_vld = '0;
  endfunction

  task automatic set_nop();
    d_flush = 0; d_stall = 0; d_dv = '0; d_ncmt = 0;
    for (int i = 0; i < 2; i++) begin d_rs1[i] = '0; d_rs2[i] = '0; d_rd[i] = '0; d_we[i] = 0; end
  endtask

  task automatic set_pair(logic [1:0] dv, int a1, int a2, int ad, bit aw,
                          int b1, int b2, int bd, bit bw);
    d_dv = dv;
    d_rs1[0] = 5'(a1); d_rs2[0] = 5'(a2); d_rd[0] = 5'(ad); d_we[0] = aw;
    d_rs1[1] = 5'(b1); d_rs2[1] = 5'(b2); d_rd[1] = 5'(bd); d_we[1] = bw;
  endtask

  task automatic drive_idle();
    bus.flush = 0; bus.stall_rename = 0; bus.decode_valid = '0;
    bus.decode_rs1_0 = '0; bus.decode_rs2_0 = '0; bus.decode_rd_0 = '0; bus.decode_rd_we_0 = 0;
    bus.decode_rs1_1 = '0; bus.decode_rs2_1 = '0; bus.decode_rd_1 = '0; bus.decode_rd_we_1 = 0;
    bus.commit_valid = '0; bus.commit_rd_0 = '0; bus.commit_rd_1 = '0;
    bus.commit_prd_0 = '0; bus.commit_prd_1 = '0; bus.commit_old_prd_0 = '0; bus.commit_old_prd_1 = '0;
  endtask

  task automatic check_outputs();
    chk("rename_valid", int'(bus.rename_valid), int'(e_vld));
    if (e_vld[0]) begin
      chk("prs1_0", int'(bus.prs1_0), e_prs1[0]);
      chk("prs2_0", int'(bus.prs2_0), e_prs2[0]);
      chk("prd_0", int'(bus.prd_0), e_prd[0]);
      chk("old_prd_0", int'(bus.old_prd_0), e_old[0]);
    end
    if (e_vld[1]) begin
      chk("prs1_1", int'(bus.prs1_1), e_prs1[1]);
      chk("prs2_1", int'(bus.prs2_1), e_prs2[1]);
      chk("prd_1", int'(bus.prd_1), e_prd[1]);
      chk("old_prd_1", int'(bus.old_prd_1), e_old[1]);
    end
  endtask

  // one clock: drive at negedge, compare, then advance the model to the following edge
  task automatic tick();
    int nc, nneed;
    bit e_ready, acc;
    bit need[2];
    int c_rd[2], c_prd[2], c_old[2];
    int n_prs1[2], n_prs2[2], n_prd[2], n_old[2];
    @(negedge clk);
    nc = d_ncmt;
    if (nc > rob_rd.size()) nc = rob_rd.size();
    if (nc > 2) nc = 2;
    for (int i = 0; i < 2; i++) begin
      c_rd[i] = 0; c_prd[i] = 0; c_old[i] = 0;
      if (i < nc) begin c_rd[i] = rob_rd[i]; c_prd[i] = rob_prd[i]; c_old[i] = rob_old[i]; end
    end
    bus.flush = d_flush; bus.stall_rename = d_stall; bus.decode_valid = d_dv;
    bus.decode_rs1_0 = d_rs1[0]; bus.decode_rs2_0 = d_rs2[0]; bus.decode_rd_0 = d_rd[0]; bus.decode_rd_we_0 = d_we[0];
    bus.decode_rs1_1 = d_rs1[1]; bus.decode_rs2_1 = d_rs2[1]; bus.decode_rd_1 = d_rd[1]; bus.decode_rd_we_1 = d_we[1];
    bus.commit_valid = (nc == 0) ? 2'b00 : (nc == 1) ? 2'b01 : 2'b11;
    bus.commit_rd_0 = 5'(c_rd[0]); bus.commit_prd_0 = 6'(c_prd[0]); bus.commit_old_prd_0 = 6'(c_old[0]);
    bus.commit_rd_1 = 5'(c_rd[1]); bus.commit_prd_1 = 6'(c_prd[1]); bus.commit_old_prd_1 = 6'(c_old[1]);
    #1;
    check_outputs();
    nneed = 0;
    for (int i = 0; i < 2; i++) begin
      need[i] = d_dv[i] && d_we[i] && (d_rd[i] != 0);
      nneed += int'(need[i]);
    end
    e_ready = !d_stall && !d_flush && ((FL_DEPTH - spec_off) >= nneed);
    chk("decode_ready", int'(bus.decode_ready), int'(e_ready));
    chk("freelist_err", int'(bus.freelist_err), 0);
    acc = e_ready && (d_dv != 0);
    // slots renamed one after another: slot 1 sees slot 0's map write
    for (int i = 0; i < 2; i++) begin
      n_prs1[i] = spec_map[d_rs1[i]];
      n_prs2[i] = spec_map[d_rs2[i]];
      n_prd[i] = 0; n_old[i] = 0;
      if (acc && need[i]) begin
        n_prd[i] = fl[spec_off];
        n_old[i] = spec_map[d_rd[i]];
        spec_map[d_rd[i]] = n_prd[i];
        spec_off++;
        rob_rd.push_back(int'(d_rd[i])); rob_prd.push_back(n_prd[i]); rob_old.push_back(n_old[i]);
      end
    end
    for (int i = 0; i < nc; i++) begin
      void'(rob_rd.pop_front()); void'(rob_prd.pop_front()); void'(rob_old.pop_front());
      cmt_map[c_rd[i]] = c_prd[i];
      void'(fl.pop_front());
      spec_off--;
      fl.push_back(c_old[i]);
    end
    if (d_flush) begin
      spec_map = cmt_map;
      spec_off = 0;
      rob_rd.delete(); rob_prd.delete(); rob_old.delete();
    end
    if (d_flush) e_vld = '0;
    else if (acc) begin
      e_vld = d_dv;
      for (int i = 0; i < 2; i++) begin
        e_prs1[i] = n_prs1[i]; e_prs2[i] = n_prs2[i]; e_prd[i] = n_prd[i]; e_old[i] = n_old[i];
      end
    end else if (!d_stall) e_vld = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_rename_valid", int'(bus.rename_valid), 0);
    chk("rst_prd_0", int'(bus.prd_0), 0);
    chk("rst_old_prd_1", int'(bus.old_prd_1), 0);
    chk("rst_freelist_err", int'(bus.freelist_err), 0);
    model_reset();
    set_nop();
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cprob;
    set_nop();
    drive_idle();
    model_reset();
    do_reset();

    // x5 / x6 straight out of reset
    set_pair(2'b11, 1, 2, 5, 1, 3, 4, 6, 1);
    tick();
    after_edge();
    chk("lit_prd_0", int'(bus.prd_0), 32);
    chk("lit_prd_1", int'(bus.prd_1), 33);
    chk("lit_old_prd_0", int'(bus.old_prd_0), 5);
    chk("lit_old_prd_1", int'(bus.old_prd_1), 6);
    chk("lit_rename_valid", int'(bus.rename_valid), 3);

    // stall holds the output register and pointers
    d_stall = 1;
    set_pair(2'b11, 1, 2, 8, 1, 3, 4, 9, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lit_stall_ready", int'(bus.decode_ready), 0);
      after_edge();
      chk("lit_stall_prd_0", int'(bus.prd_0), 32);
      chk("lit_stall_valid", int'(bus.rename_valid), 3);
    end
    d_stall = 0;
    tick();
    after_edge();
    chk("lit_post_stall_prd_0", int'(bus.prd_0), 34);

    // intra-pair bypass on x7
    do_reset();
    set_pair(2'b11, 1, 2, 7, 1, 7, 3, 7, 1);
    tick();
    after_edge();
    chk("lit_byp_prs1_1", int'(bus.prs1_1), 32);
    chk("lit_byp_prd_0", int'(bus.prd_0), 32);
    chk("lit_byp_prd_1", int'(bus.prd_1), 33);
    chk("lit_byp_old_prd_0", int'(bus.old_prd_0), 7);
    chk("lit_byp_old_prd_1", int'(bus.old_prd_1), 32);

    // drain the free list, then free one register by commit
    do_reset();
    set_pair(2'b11, 0, 0, 5, 1, 0, 0, 6, 1);
    tick();
    for (int k = 1; k < 16; k++) begin
      set_pair(2'b11, k, 0, (2 * k) % 31 + 1, 1, 0, k, (2 * k + 1) % 31 + 1, 1);
      tick();
    end
    set_pair(2'b11, 1, 2, 3, 1, 4, 5, 6, 1);
    tick();
    chk("lit_full_ready_writer", int'(bus.decode_ready), 0);
    set_pair(2'b11, 1, 2, 3, 0, 4, 5, 6, 0);
    tick();
    chk("lit_full_ready_store", int'(bus.decode_ready), 1);
    set_pair(2'b01, 1, 2, 9, 1, 0, 0, 0, 0);
    d_ncmt = 1;
    tick();
    chk("lit_commit_same_cycle_ready", int'(bus.decode_ready), 0);
    d_ncmt = 0;
    tick();
    chk("lit_commit_next_cycle_ready", int'(bus.decode_ready), 1);
    after_edge();
    chk("lit_reuse_prd_0", int'(bus.prd_0), 5);

    // three pairs, commit the first together with a flush
    do_reset();
    set_pair(2'b11, 0, 0, 1, 1, 0, 0, 2, 1); tick();
    set_pair(2'b11, 0, 0, 3, 1, 0, 0, 4, 1); tick();
    set_pair(2'b11, 0, 0, 5, 1, 0, 0, 6, 1); tick();
    set_pair(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    d_flush = 1; d_ncmt = 2;
    tick();
    d_flush = 0; d_ncmt = 0;
    set_pair(2'b11, 1, 3, 10, 1, 2, 5, 11, 1);
    tick();
    after_edge();
    chk("lit_flush_prs1_0", int'(bus.prs1_0), 32);
    chk("lit_flush_prs2_0", int'(bus.prs2_0), 3);
    chk("lit_flush_prs1_1", int'(bus.prs1_1), 33);
    chk("lit_flush_prs2_1", int'(bus.prs2_1), 5);
    chk("lit_flush_prd_0", int'(bus.prd_0), 34);
    chk("lit_flush_prd_1", int'(bus.prd_1), 35);

    // random traffic, alternating starved and generous commit phases
    for (int cyc = 0; cyc < 2400; cyc++) begin
      cprob = ((cyc / 200) % 2 == 1) ? 75 : 12;
      d_flush = ($urandom_range(0, 39) == 0);
      d_stall = ($urandom_range(0, 5) == 0);
      d_dv    = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        d_rs1[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        d_rs2[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        d_rd[i]  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        d_we[i]  = ($urandom_range(0, 3) != 0);
      end
      d_ncmt = ($urandom_range(0, 99) < cprob) ? $urandom_range(1, 2) : 0;
      tick();
      if (cyc == 1300) do_reset();
    end
    set_nop();
    tick();

`ifdef RENAME_FREELIST_CHECK_EN
    @(negedge clk);
    drive_idle();
    bus.commit_valid = 2'b01; bus.commit_rd_0 = 5'd1; bus.commit_prd_0 = 6'd32; bus.commit_old_prd_0 = 6'd0;
    after_edge();
    chk("err_set", int'(bus.freelist_err), 1);
    @(negedge clk);
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", int'(bus.freelist_err), 1);
    do_reset();
    chk("err_cleared", int'(bus.freelist_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
